// File: rtl/mem_port_arbiter_if.sv
// Bundle between the core (fetch / MEM stages, hazard unit), the shared
// memory port and the arbiter. The arbiter connects through the master
// modport. The environment (core plus memory) connects through the slave
// modport. The dbg* signals expose the arbiter's internal state for checkers.
//
// Memory handshake: mem_req is the request valid and mem_addr_ok is its ready.
// The address phase completes on the edge where both are high. During that
// phase mem_wr/mem_size/mem_addr/mem_wdata stay stable. After that, mem_req
// stays low until mem_data_ok closes the transaction. Only one transaction is
// ever outstanding.
interface mem_port_arbiter_if;
    // fetch stage
    logic        inst_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        i_stall;
    // MEM stage
    logic        data_en;
    logic [3:0]  data_wen;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        d_stall;
    // hazard unit
    logic        longest_stall;
    // memory port
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    // debug visibility
    logic [1:0]  dbgState;
    logic        dbgOwner;
    logic        dbgInstDone;
    logic        dbgDataDone;

    modport master (
        input  inst_en, inst_addr,
        output inst_rdata, i_stall,
        input  data_en, data_wen, data_size, data_addr, data_wdata,
        output data_rdata, d_stall,
        input  longest_stall,
        output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output dbgState, dbgOwner, dbgInstDone, dbgDataDone
    );

    modport slave (
        output inst_en, inst_addr,
        input  inst_rdata, i_stall,
        output data_en, data_wen, data_size, data_addr, data_wdata,
        input  data_rdata, d_stall,
        output longest_stall,
        input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  dbgState, dbgOwner, dbgInstDone, dbgDataDone
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Puts instruction fetches and data accesses onto one SRAM-like port, one
// transaction at a time. Data goes first because it belongs to the older
// instruction. Each requester's result and its done flag are held until the
// pipeline advances (longest_stall == 0).
module mem_port_arbiter #(
    parameter logic [31:0] RESET_PC_WORD = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arbState_e;

    arbState_e   state;
    logic        owner;      // 0 = instruction transaction, 1 = data transaction
    logic        instDone;
    logic        dataDone;
    logic        memReq;
    logic        memWr;
    logic [1:0]  memSize;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] instRdata;
    logic [31:0] dataRdata;

    logic instPend;
    logic dataPend;

    assign instPend = bus.inst_en & ~instDone;
    assign dataPend = bus.data_en & ~dataDone;

    // Stalls are combinational so a new request stalls on its first cycle.
    assign bus.i_stall = instPend;
    assign bus.d_stall = dataPend;

    assign bus.mem_req    = memReq;
    assign bus.mem_wr     = memWr;
    assign bus.mem_size   = memSize;
    assign bus.mem_addr   = memAddr;
    assign bus.mem_wdata  = memWdata;
    assign bus.inst_rdata = instRdata;
    assign bus.data_rdata = dataRdata;

    assign bus.dbgState    = state;
    assign bus.dbgOwner    = owner;
    assign bus.dbgInstDone = instDone;
    assign bus.dbgDataDone = dataDone;

    // Transaction FSM with registered memory-side outputs, result capture and done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            instDone  <= 1'b0;
            dataDone  <= 1'b0;
            memReq    <= 1'b0;
            memWr     <= 1'b0;
            memSize   <= 2'd0;
            memAddr   <= 32'd0;
            memWdata  <= 32'd0;
            instRdata <= RESET_PC_WORD;
            dataRdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (dataPend) begin
                        memAddr  <= bus.data_addr;
                        memWdata <= bus.data_wdata;
                        memWr    <= |bus.data_wen;
                        memSize  <= bus.data_size;
                        owner    <= 1'b1;
                        memReq   <= 1'b1;
                        state    <= ADDR;
                    end else if (instPend) begin
                        memAddr  <= bus.inst_addr;
                        memWr    <= 1'b0;
                        memSize  <= 2'd2;
                        owner    <= 1'b0;
                        memReq   <= 1'b1;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.mem_addr_ok) begin
                        memReq <= 1'b0;
                        state  <= DATA;
                    end
                end
                DATA: begin
                    // A withdrawn request (flush) still has to drain the
                    // transaction, but its result is dropped.
                    if (bus.mem_data_ok) begin
                        state <= IDLE;
                        if (owner) begin
                            if (bus.data_en) begin
                                dataRdata <= bus.mem_rdata;
                                dataDone  <= 1'b1;
                            end
                        end else if (bus.inst_en) begin
                            instRdata <= bus.mem_rdata;
                            instDone  <= 1'b1;
                        end
                    end
                end
                default: begin
                    memReq <= 1'b0;
                    state  <= IDLE;
                end
            endcase
            // If the pipeline advances on the same edge, the result belonged
            // to the old instruction. This clear comes last so it wins.
            if (!bus.longest_stall) begin
                instDone <= 1'b0;
                dataDone <= 1'b0;
            end
        end
    end

endmodule
